// File: rtl/jt49_eg.sv
// Envelope generator for AY-3-8910 / YM2149 style PSG: period prescaler, step counter and RUN/HOLD shape FSM.
// Define JT49_EG32_EN for 32-step YM2149 envelopes; default is 16-step AY-3-8910 envelopes.
module jt49_eg (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen256,
  input  logic [15:0] period,
  input  logic [3:0]  shape,
  input  logic        restart,
  output logic [4:0]  env,
  output logic        held
);

`ifdef JT49_EG32_EN
  localparam int SW = 5;
`else
  localparam int SW = 4;
`endif

  localparam logic [SW-1:0] STEP_MAX = '1;
  localparam logic [SW-1:0] STEP_ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [15:0]   cnt;
  logic [15:0]   lim;
  logic          tick;
  logic [SW-1:0] step;
  logic [SW-1:0] nxt_step;
  logic          dir;
  logic          nxt_dir;
  logic [4:0]    nxt_env;

  logic cont, att, alt, hold;
  assign cont = shape[3];
  assign att  = shape[2];
  assign alt  = shape[1];
  assign hold = shape[0];

  // dir=1 counts up from 0, dir=0 counts down from the top level.
  function automatic logic [SW-1:0] level(input logic [SW-1:0] s, input logic d);
    return d ? s : (STEP_MAX - s);
  endfunction

  // The 16-step level is widened by repeating its MSB so full scale still reaches 31.
  function automatic logic [4:0] to_env(input logic [SW-1:0] lvl);
`ifdef JT49_EG32_EN
    return lvl;
`else
    return {lvl, lvl[SW-1]};
`endif
  endfunction

  // A period of 0 behaves like 1, so the limit saturates at 0.
  always_comb begin
    lim  = (period == 16'd0) ? 16'd0 : (period - 16'd1);
    tick = cen256 && (cnt >= lim);
  end

  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_dir   = dir;
    nxt_env   = env;
    if (state == ST_RUN && tick) begin
      if (step == STEP_MAX) begin
        if (!cont) begin
          nxt_state = ST_HOLD;
          nxt_env   = to_env('0);
        end else if (hold) begin
          nxt_state = ST_HOLD;
          nxt_env   = (att ^ alt) ? to_env(STEP_MAX) : to_env('0);
        end else begin
          nxt_step = '0;
          nxt_dir  = dir ^ alt;
          nxt_env  = to_env(level('0, dir ^ alt));
        end
      end else begin
        nxt_step = step + STEP_ONE;
        nxt_env  = to_env(level(step + STEP_ONE, dir));
      end
    end
  end

  // Priority: rst, then restart, then the normal counting path.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 16'd0;
      step  <= '0;
      dir   <= 1'b0;
      state <= ST_HOLD;
      env   <= 5'd0;
      held  <= 1'b1;
    end else if (restart) begin
      cnt   <= 16'd0;
      step  <= '0;
      dir   <= att;
      state <= ST_RUN;
      env   <= to_env(level('0, att));
      held  <= 1'b0;
    end else begin
      if (cen256) begin
        cnt <= tick ? 16'd0 : (cnt + 16'd1);
      end
      step  <= nxt_step;
      dir   <= nxt_dir;
      state <= nxt_state;
      env   <= nxt_env;
      held  <= (nxt_state == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_jt49_eg.sv
// Directed bench for jt49_eg: reset, ramps, triangle, one-shot/hold shapes, restart collision, period corner cases.
module tb_jt49_eg;

`ifdef JT49_EG32_EN
  localparam int N = 32;
`else
  localparam int N = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen256 = 1'b0;
  logic [15:0] period = 16'd1;
  logic [3:0]  shape = 4'b0000;
  logic        restart = 1'b0;
  logic [4:0]  env;
  logic        held;

  int checks = 0;
  int errors = 0;

  jt49_eg dut (
    .clk(clk), .rst(rst), .cen256(cen256), .period(period),
    .shape(shape), .restart(restart), .env(env), .held(held)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lvl2env(input int l);
    logic [4:0] v;
    v = l[4:0];
`ifdef JT49_EG32_EN
    return v;
`else
    return {v[3:0], v[3]};
`endif
  endfunction

  function automatic int tri_level(input int s);
    int p;
    p = s % (2 * N);
    return (p < N) ? p : (2 * N - 1 - p);
  endfunction

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cen256 = 1'b1;
    cyc();
    cen256 = 1'b0;
  endtask

  task automatic do_restart(input logic [15:0] p, input logic [3:0] s);
    period  = p;
    shape   = s;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (env !== 5'd0 || held !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: env=%0d held=%0b, required env=0 held=1", env, held);
    end
    for (int i = 0; i < 1000; i++) begin
      cen256 = i[0];
      cyc();
      checks++;
      if (env !== 5'd0 || held !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle[%0d]: env=%0d held=%0b, required env=0 held=1", i, env, held);
      end
    end
    cen256 = 1'b0;
  endtask

  task automatic test_ramp();
    do_restart(16'd1, 4'b1100);
    checks++;
    if (env !== lvl2env(0) || held !== 1'b0) begin
      errors++;
      $display("FAIL ramp_start: env=%0d held=%0b, required env=%0d held=0", env, held, lvl2env(0));
    end
    for (int k = 1; k <= N + 2; k++) begin
      pulse();
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (env !== lvl2env(k % N) || held !== 1'b0) begin
          errors++;
          $display("FAIL ramp[%0d.%0d]: env=%0d held=%0b, required env=%0d held=0",
                   k, j, env, held, lvl2env(k % N));
        end
        if (j < 2) cyc();
      end
    end
  endtask

  task automatic test_triangle();
    do_restart(16'd3, 4'b1110);
    checks++;
    if (env !== lvl2env(0)) begin
      errors++;
      $display("FAIL tri_start: env=%0d, required %0d", env, lvl2env(0));
    end
    for (int j = 1; j <= 2 * N * 3 + 9; j++) begin
      pulse();
      checks++;
      if (env !== lvl2env(tri_level(j / 3)) || held !== 1'b0) begin
        errors++;
        $display("FAIL tri[%0d]: env=%0d held=%0b, required env=%0d held=0",
                 j, env, held, lvl2env(tri_level(j / 3)));
      end
      cyc();
    end
  endtask

  task automatic test_oneshot();
    do_restart(16'd1, 4'b0000);
    checks++;
    if (env !== lvl2env(N - 1) || held !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_start: env=%0d held=%0b, required env=%0d held=0", env, held, lvl2env(N - 1));
    end
    for (int k = 1; k < N; k++) begin
      pulse();
      checks++;
      if (env !== lvl2env(N - 1 - k) || held !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_desc[%0d]: env=%0d held=%0b, required env=%0d held=0",
                 k, env, held, lvl2env(N - 1 - k));
      end
    end
    for (int k = 0; k <= 200; k++) begin
      pulse();
      checks++;
      if (env !== 5'd0 || held !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_hold[%0d]: env=%0d held=%0b, required env=0 held=1", k, env, held);
      end
    end
    // CONT, ALT, HOLD with ATT=0: descend once then freeze at the top.
    do_restart(16'd1, 4'b1011);
    for (int k = 1; k < N; k++) pulse();
    checks++;
    if (env !== lvl2env(0) || held !== 1'b0) begin
      errors++;
      $display("FAIL hold_top_desc_end: env=%0d held=%0b, required env=%0d held=0", env, held, lvl2env(0));
    end
    for (int k = 0; k < 20; k++) begin
      pulse();
      checks++;
      if (env !== lvl2env(N - 1) || held !== 1'b1) begin
        errors++;
        $display("FAIL hold_top[%0d]: env=%0d held=%0b, required env=%0d held=1", k, env, held, lvl2env(N - 1));
      end
    end
  endtask

  task automatic test_restart_collision();
    do_restart(16'd3, 4'b1100);
    for (int k = 0; k < 7; k++) pulse();
    checks++;
    if (env !== lvl2env(2)) begin
      errors++;
      $display("FAIL coll_pre: env=%0d, required %0d", env, lvl2env(2));
    end
    restart = 1'b1;
    cen256  = 1'b1;
    cyc();
    restart = 1'b0;
    cen256  = 1'b0;
    checks++;
    if (env !== lvl2env(0) || held !== 1'b0) begin
      errors++;
      $display("FAIL coll_att1: env=%0d held=%0b, required env=%0d held=0", env, held, lvl2env(0));
    end
    pulse();
    pulse();
    checks++;
    if (env !== lvl2env(0)) begin
      errors++;
      $display("FAIL coll_cnt_cleared: env=%0d, required %0d", env, lvl2env(0));
    end
    pulse();
    checks++;
    if (env !== lvl2env(1)) begin
      errors++;
      $display("FAIL coll_first_step: env=%0d, required %0d", env, lvl2env(1));
    end
    shape   = 4'b1000;
    restart = 1'b1;
    cen256  = 1'b1;
    cyc();
    restart = 1'b0;
    cen256  = 1'b0;
    checks++;
    if (env !== lvl2env(N - 1)) begin
      errors++;
      $display("FAIL coll_att0: env=%0d, required %0d", env, lvl2env(N - 1));
    end
  endtask

  task automatic test_period_change();
    do_restart(16'd5, 4'b1100);
    for (int k = 0; k < 4; k++) pulse();
    checks++;
    if (env !== lvl2env(0)) begin
      errors++;
      $display("FAIL per_before: env=%0d, required %0d", env, lvl2env(0));
    end
    period = 16'd2;
    pulse();
    checks++;
    if (env !== lvl2env(1)) begin
      errors++;
      $display("FAIL per_shrink_tick: env=%0d, required %0d", env, lvl2env(1));
    end
    pulse();
    checks++;
    if (env !== lvl2env(1)) begin
      errors++;
      $display("FAIL per_new_wait: env=%0d, required %0d", env, lvl2env(1));
    end
    pulse();
    checks++;
    if (env !== lvl2env(2)) begin
      errors++;
      $display("FAIL per_new_tick: env=%0d, required %0d", env, lvl2env(2));
    end
  endtask

  task automatic test_shape_change();
    do_restart(16'd1, 4'b1100);
    for (int k = 0; k < 3; k++) pulse();
    shape = 4'b0000;
    for (int k = 4; k < N; k++) begin
      pulse();
      checks++;
      if (env !== lvl2env(k) || held !== 1'b0) begin
        errors++;
        $display("FAIL shape_mid[%0d]: env=%0d held=%0b, required env=%0d held=0", k, env, held, lvl2env(k));
      end
    end
    pulse();
    checks++;
    if (env !== 5'd0 || held !== 1'b1) begin
      errors++;
      $display("FAIL shape_cycle_end: env=%0d held=%0b, required env=0 held=1", env, held);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      do_restart(p[15:0], 4'b1100);
      cen256 = 1'b1;
      for (int k = 1; k <= N + 3; k++) begin
        cyc();
        checks++;
        if (env !== lvl2env(k % N)) begin
          errors++;
          $display("FAIL b2b_p%0d[%0d]: env=%0d, required %0d", p, k, env, lvl2env(k % N));
        end
      end
      cen256 = 1'b0;
    end
    do_restart(16'd1, 4'b1100);
    for (int k = 0; k < 5; k++) pulse();
    rst     = 1'b1;
    restart = 1'b1;
    cen256  = 1'b1;
    cyc();
    rst     = 1'b0;
    restart = 1'b0;
    cen256  = 1'b0;
    checks++;
    if (env !== 5'd0 || held !== 1'b1) begin
      errors++;
      $display("FAIL midramp_rst: env=%0d held=%0b, required env=0 held=1", env, held);
    end
    for (int k = 0; k < 3; k++) pulse();
    checks++;
    if (env !== 5'd0 || held !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_idle: env=%0d held=%0b, required env=0 held=1", env, held);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_triangle();
    test_oneshot();
    test_restart_collision();
    test_period_change();
    test_shape_change();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
